// File: rtl/cbud_mod_counter_pkg.sv
// cbud_pkg: shared constants and helpers for the cbud_* counter family
// Contents: direction encodings, WIDTH legality check, terminal-condition function
package cbud_pkg;
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    function automatic bit width_ok(input int w);
        return w >= 2 && w <= 32;
    endfunction

    // Terminal: counting down terminates at 0, counting up at or beyond maxv
    function automatic logic term_f(input logic [31:0] q, input logic [31:0] maxv, input logic dnup);
        return dnup == DIR_DN ? q == 32'd0 : q >= maxv;
    endfunction
endpackage

// File: rtl/cbud_mod_counter_if.sv
// cbud_mod_counter_if: control/data bundle of one cbud_mod_counter stage
// Signals: D/LD load, EN/CAI count enables, DNUP direction, MAXV terminal value,
//          Q count, CAO combinational carry out, WRAP registered wrap pulse
// Modports: master drives controls and observes results, slave is the counter
interface cbud_mod_counter_if #(parameter int WIDTH = 4);
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] MAXV;
    logic [WIDTH-1:0] Q;
    logic LD;
    logic EN;
    logic CAI;
    logic DNUP;
    logic CAO;
    logic WRAP;

    modport master (output D, LD, EN, CAI, DNUP, MAXV, input Q, CAO, WRAP);
    modport slave  (input D, LD, EN, CAI, DNUP, MAXV, output Q, CAO, WRAP);
endinterface

// File: rtl/cbud_mod_counter_term.sv
// cbud_term: combinational terminal detect shared by carry out and next-state logic
// Ports: q current count, maxv terminal value, dnup direction (1 = down), t terminal flag
module cbud_term
    import cbud_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] maxv,
    input  logic             dnup,
    output logic             t
);
    assign t = term_f(32'(q), 32'(maxv), dnup);
endmodule

// File: rtl/cbud_mod_counter.sv
// cbud_mod_counter: parametrised modulo-(MAXV+1) up/down counter with cascade carry
// Ports: CLK clock, CS synchronous active-high reset, bus (cbud_mod_counter_if.slave)
// Build option: define CBUD_MOD_SATURATE_EN to hold at the terminal value instead of wrapping
module cbud_mod_counter
    import cbud_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input logic              CLK,
    input logic              CS,
    cbud_mod_counter_if.slave bus
);
    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("cbud_mod_counter: WIDTH must be within 2..32");
    end

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] nxt;
    logic             t;
    logic             cnt;
    logic             dn;
    logic             pulse;
    logic             wrap;

    cbud_term #(.WIDTH(WIDTH)) u_term (
        .q    (q),
        .maxv (bus.MAXV),
        .dnup (bus.DNUP),
        .t    (t)
    );

    assign cnt     = bus.CAI && bus.EN;
    assign dn      = bus.DNUP == DIR_DN;
    assign bus.CAO = cnt && t;
    assign bus.Q   = q;
    assign bus.WRAP = wrap;

`ifdef CBUD_MOD_SATURATE_EN
    logic sat_hold;
    logic sat_dn;
    // At the limit, up clamps to MAXV (also pulls an out-of-range Q back) and down stays at 0
    assign nxt   = t ? (dn ? '0 : bus.MAXV) : (dn ? q - ONE : q + ONE);
    // Only the first terminal count in a given direction reports WRAP
    assign pulse = cnt && t && !(sat_hold && sat_dn == bus.DNUP);
    always_ff @(posedge CLK) begin
        if (CS || bus.LD) begin
            sat_hold <= 1'b0;
        end else if (cnt) begin
            sat_hold <= t;
            sat_dn   <= bus.DNUP;
        end
    end
`else
    assign nxt   = t ? (dn ? bus.MAXV : '0) : (dn ? q - ONE : q + ONE);
    assign pulse = cnt && t;
`endif

    always_ff @(posedge CLK) begin
        q    <= CS ? RST_VAL : bus.LD ? bus.D : cnt ? nxt : q;
        wrap <= !CS && !bus.LD && pulse;
    end
endmodule
